// File: rtl/timer_16bit_count_unit_pkg.sv
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared constants and clock-select encodings for the Timer1 count unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  localparam int TCNT_W      = 16;
  localparam int WGM12_BIT   = 3;
  localparam int OCF_BIT_DEF = 4;
  localparam int TOV_BIT_DEF = 2;

  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_DIV1     = 3'b001,
    CS_DIV8     = 3'b010,
    CS_DIV64    = 3'b011,
    CS_DIV256   = 3'b100,
    CS_DIV1024  = 3'b101,
    CS_EXT_FALL = 3'b110,
    CS_EXT_RISE = 3'b111
  } cs_e;

endpackage

`default_nettype wire

// File: rtl/timer_16bit_count_unit_if.sv
// ============================================================================
// Module  : timer_16bit_count_unit_if
// Brief   : Register-file side bus of the Timer1 count unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface timer_16bit_count_unit_if;

  logic [7:0]  TCCR1B_in;
  logic [7:0]  TCNT1H_in;
  logic [7:0]  TCNT1L_in;
  logic [7:0]  OCR1AH_in;
  logic [7:0]  OCR1AL_in;
  logic [7:0]  TIMSK_in;
  logic [7:0]  TIFR_in;
  logic        cpu_tcnt_we;
  logic [15:0] cpu_tcnt_data;
  logic        psr10;
  logic        t1_pin;
  logic [7:0]  TCNT1H_next;
  logic [7:0]  TCNT1L_next;
  logic        ocf1a_set;
  logic        tov1_set;
  logic        irq_compa;
  logic        irq_ovf;
  logic        count_tick;

  modport master (
    output TCCR1B_in, TCNT1H_in, TCNT1L_in, OCR1AH_in, OCR1AL_in,
    output TIMSK_in, TIFR_in, cpu_tcnt_we, cpu_tcnt_data, psr10, t1_pin,
    input  TCNT1H_next, TCNT1L_next, ocf1a_set, tov1_set,
    input  irq_compa, irq_ovf, count_tick
  );

  modport slave (
    input  TCCR1B_in, TCNT1H_in, TCNT1L_in, OCR1AH_in, OCR1AL_in,
    input  TIMSK_in, TIFR_in, cpu_tcnt_we, cpu_tcnt_data, psr10, t1_pin,
    output TCNT1H_next, TCNT1L_next, ocf1a_set, tov1_set,
    output irq_compa, irq_ovf, count_tick
  );

endinterface

`default_nettype wire

// File: rtl/timer_16bit_count_unit_clock_select.sv
// ============================================================================
// Module  : timer_clock_select
// Brief   : Prescaler, T1 pin synchroniser/edge detect and CS1 mux -> count_tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_clock_select
  import timer_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 10,
  parameter int SYNC_STAGES     = 2
) (
  input  wire logic       clk_i,
  input  wire logic       rst_ni,
  input  wire logic [2:0] cs_i,
  input  wire logic       psr10_i,
  input  wire logic       t1_pin_i,
  output logic            count_tick_o
);

  localparam logic [PRESCALER_WIDTH-1:0] PRE_ONE = PRESCALER_WIDTH'(1);

  logic [PRESCALER_WIDTH-1:0] prescaler_q;
  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       t1_prev_q;
  logic                       tick_q;
  logic                       tick_d;
  logic                       t1_sync;

  assign t1_sync      = sync_q[SYNC_STAGES-1];
  assign count_tick_o = tick_q;

  // Prescaler taps fire on the all-ones phase of each divider.
  always_comb begin
    tick_d = 1'b0;
    case (cs_e'(cs_i))
      CS_STOP:     tick_d = 1'b0;
      CS_DIV1:     tick_d = 1'b1;
      CS_DIV8:     tick_d = &prescaler_q[2:0];
      CS_DIV64:    tick_d = &prescaler_q[5:0];
      CS_DIV256:   tick_d = &prescaler_q[7:0];
      CS_DIV1024:  tick_d = &prescaler_q[9:0];
      CS_EXT_FALL: tick_d = t1_prev_q & ~t1_sync;
      CS_EXT_RISE: tick_d = ~t1_prev_q & t1_sync;
      default:     tick_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescaler_q <= '0;
      sync_q      <= '0;
      t1_prev_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      prescaler_q <= psr10_i ? '0 : prescaler_q + PRE_ONE;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], t1_pin_i};
      t1_prev_q   <= t1_sync;
      tick_q      <= tick_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_16bit_count_unit.sv
// ============================================================================
// Module  : timer_16bit_count_unit
// Brief   : Timer1 next-count / compare engine feeding the 16-bit register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_16bit_count_unit
  import timer_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int OCF_BIT         = OCF_BIT_DEF,
  parameter int TOV_BIT         = TOV_BIT_DEF
) (
  input  wire logic                  sysClock,
  input  wire logic                  system_reset,
  timer_16bit_count_unit_if.slave    bus
);

  localparam logic [TCNT_W-1:0] TCNT_MAX = {TCNT_W{1'b1}};
  localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);

  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] ocr;
  logic [TCNT_W-1:0] tcnt_next;
  logic              ctc;
  logic              tick;
  logic              match;
  logic              ocf_set;
  logic              tov_set;
  logic              blk_q;
  logic              blk_d;
  logic              irq_compa_q;
  logic              irq_ovf_q;
  logic              unused_bits;

  assign tcnt  = {bus.TCNT1H_in, bus.TCNT1L_in};
  assign ocr   = {bus.OCR1AH_in, bus.OCR1AL_in};
  assign ctc   = bus.TCCR1B_in[WGM12_BIT];
  assign match = (tcnt == ocr);

  timer_clock_select #(
    .PRESCALER_WIDTH (PRESCALER_WIDTH),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_clk_sel (
    .clk_i        (sysClock),
    .rst_ni       (system_reset),
    .cs_i         (bus.TCCR1B_in[2:0]),
    .psr10_i      (bus.psr10),
    .t1_pin_i     (bus.t1_pin),
    .count_tick_o (tick)
  );

  // A CPU write always wins over a coincident tick, which is then lost.
  always_comb begin
    tcnt_next = tcnt;
    ocf_set   = 1'b0;
    tov_set   = 1'b0;
    blk_d     = blk_q;
    if (!system_reset) begin
      tcnt_next = tcnt;
    end else if (bus.cpu_tcnt_we) begin
      tcnt_next = bus.cpu_tcnt_data;
      blk_d     = 1'b1;
    end else if (tick) begin
      blk_d = 1'b0;
      if (ctc && match) begin
        tcnt_next = '0;
        ocf_set   = ~blk_q;
        tov_set   = (tcnt == TCNT_MAX);
      end else if (tcnt == TCNT_MAX) begin
        tcnt_next = '0;
        tov_set   = ~ctc;
        ocf_set   = ~ctc & (ocr == TCNT_MAX) & ~blk_q;
      end else begin
        tcnt_next = tcnt + TCNT_ONE;
        ocf_set   = ~ctc & match & ~blk_q;
      end
    end
  end

  always_ff @(posedge sysClock or negedge system_reset) begin
    if (!system_reset) begin
      blk_q       <= 1'b0;
      irq_compa_q <= 1'b0;
      irq_ovf_q   <= 1'b0;
    end else begin
      blk_q       <= blk_d;
      irq_compa_q <= bus.TIFR_in[OCF_BIT] & bus.TIMSK_in[OCF_BIT];
      irq_ovf_q   <= bus.TIFR_in[TOV_BIT] & bus.TIMSK_in[TOV_BIT];
    end
  end

  assign bus.TCNT1H_next = tcnt_next[15:8];
  assign bus.TCNT1L_next = tcnt_next[7:0];
  assign bus.ocf1a_set   = ocf_set;
  assign bus.tov1_set    = tov_set;
  assign bus.irq_compa   = irq_compa_q;
  assign bus.irq_ovf     = irq_ovf_q;
  assign bus.count_tick  = tick;

  assign unused_bits = ^{bus.TCCR1B_in[7:4], bus.TIFR_in, bus.TIMSK_in};

endmodule

`default_nettype wire

// File: tb/tb_timer_16bit_count_unit.sv
// ============================================================================
// Module  : tb_timer_16bit_count_unit
// Brief   : Self-checking bench: cycle model of the count unit plus directed cases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_16bit_count_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tcnt = 16'h0000;
  logic        preset_req;
  logic [15:0] preset_val;
  logic        chk_en;
  int          n_checks = 0;
  int          n_err    = 0;

  timer_16bit_count_unit_if bus ();

  timer_16bit_count_unit #(
    .PRESCALER_WIDTH (10),
    .SYNC_STAGES     (2),
    .OCF_BIT         (4),
    .TOV_BIT         (2)
  ) dut (
    .sysClock     (clk),
    .system_reset (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Bench stands in for the register file: TCNT1 reloads from the unit every cycle.
  assign bus.TCNT1H_in = tcnt[15:8];
  assign bus.TCNT1L_in = tcnt[7:0];
  always @(posedge clk) tcnt <= preset_req ? preset_val : {bus.TCNT1H_next, bus.TCNT1L_next};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cyc;
  logic [3:0] m_pins;
  logic       m_tick, m_blk, m_irqc, m_irqo;

  function automatic logic tick_due(input logic [2:0] cs, input int pre,
                                    input logic now_lvl, input logic old_lvl);
    case (cs)
      3'd1:    return 1'b1;
      3'd2:    return (pre % 8) == 7;
      3'd3:    return (pre % 64) == 63;
      3'd4:    return (pre % 256) == 255;
      3'd5:    return (pre % 1024) == 1023;
      3'd6:    return old_lvl && !now_lvl;
      3'd7:    return !old_lvl && now_lvl;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_pins <= 4'b0;
      m_tick <= 1'b0;
      m_blk  <= 1'b0;
      m_irqc <= 1'b0;
      m_irqo <= 1'b0;
    end else begin
      // m_pins[1] is the pin two edges ago (synchronised), m_pins[2] one edge older.
      m_tick <= tick_due(bus.TCCR1B_in[2:0], m_cyc, m_pins[1], m_pins[2]);
      m_cyc  <= bus.psr10 ? 0 : (m_cyc + 1) % 1024;
      m_pins <= {m_pins[2:0], bus.t1_pin};
      if (bus.cpu_tcnt_we) m_blk <= 1'b1;
      else if (m_tick)     m_blk <= 1'b0;
      m_irqc <= bus.TIFR_in[4] & bus.TIMSK_in[4];
      m_irqo <= bus.TIFR_in[2] & bus.TIMSK_in[2];
    end
  end

  logic [15:0] e_next, e_ocr;
  logic        e_ocf, e_tov, e_ctc, e_wrap;

  always begin
    @(negedge clk);
    #1;
    if (chk_en && rst_n) begin
      e_ocr = {bus.OCR1AH_in, bus.OCR1AL_in};
      e_ctc = bus.TCCR1B_in[3];
      e_wrap = e_ctc ? (tcnt == e_ocr || tcnt == 16'hFFFF) : (tcnt == 16'hFFFF);
      if (bus.cpu_tcnt_we) e_next = bus.cpu_tcnt_data;
      else if (!m_tick)    e_next = tcnt;
      else if (e_wrap)     e_next = 16'h0000;
      else                 e_next = 16'(tcnt + 16'd1);
      e_ocf = m_tick && !bus.cpu_tcnt_we && !m_blk && (tcnt == e_ocr);
      e_tov = m_tick && !bus.cpu_tcnt_we && (tcnt == 16'hFFFF) && (!e_ctc || e_ocr == 16'hFFFF);
      check("model_tick", 32'(bus.count_tick), 32'(m_tick));
      check("model_next", 32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'(e_next));
      check("model_ocf",  32'(bus.ocf1a_set), 32'(e_ocf));
      check("model_tov",  32'(bus.tov1_set), 32'(e_tov));
      check("model_irqc", 32'(bus.irq_compa), 32'(m_irqc));
      check("model_irqo", 32'(bus.irq_ovf), 32'(m_irqo));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [15:0] ctc_seq [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3};
  logic        ocf_seq [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    chk_en = 1'b0;
    preset_req = 1'b0;
    preset_val = 16'h0;
    bus.TCCR1B_in = 8'h00;
    bus.OCR1AH_in = 8'h00;
    bus.OCR1AL_in = 8'h00;
    bus.TIMSK_in = 8'h00;
    bus.TIFR_in = 8'h00;
    bus.cpu_tcnt_we = 1'b0;
    bus.cpu_tcnt_data = 16'h0;
    bus.psr10 = 1'b0;
    bus.t1_pin = 1'b0;

    #3;
    check("rst_tick", 32'(bus.count_tick), 32'd0);
    check("rst_irqc", 32'(bus.irq_compa), 32'd0);
    check("rst_irqo", 32'(bus.irq_ovf), 32'd0);
    check("rst_ocf",  32'(bus.ocf1a_set), 32'd0);
    check("rst_tov",  32'(bus.tov1_set), 32'd0);
    check("rst_next", 32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'h0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // CTC on OCR1A=3, tick every cycle
    bus.OCR1AL_in = 8'h03;
    bus.TCCR1B_in = 8'h09;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      check("ctc_tcnt", 32'(tcnt), 32'(ctc_seq[i]));
      check("ctc_ocf",  32'(bus.ocf1a_set), 32'(ocf_seq[i]));
      check("ctc_tov",  32'(bus.tov1_set), 32'd0);
    end

    // Normal-mode overflow from 0xFFFE
    @(negedge clk);
    bus.TCCR1B_in = 8'h01;
    preset_req = 1'b1;
    preset_val = 16'hFFFE;
    @(negedge clk);
    preset_req = 1'b0;
    #2;
    check("ovf_tcnt0", 32'(tcnt), 32'hFFFE);
    check("ovf_tov0",  32'(bus.tov1_set), 32'd0);
    @(negedge clk); #2;
    check("ovf_tcnt1", 32'(tcnt), 32'hFFFF);
    check("ovf_tov1",  32'(bus.tov1_set), 32'd1);
    check("ovf_next1", 32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'h0);
    @(negedge clk); #2;
    check("ovf_tcnt2", 32'(tcnt), 32'h0);
    check("ovf_tov2",  32'(bus.tov1_set), 32'd0);

    // Divide-by-8 restarted by psr10
    @(negedge clk);
    bus.TCCR1B_in = 8'h02;
    bus.psr10 = 1'b1;
    @(negedge clk);
    bus.psr10 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #2;
      check("div8_tick", 32'(bus.count_tick), 32'((k == 8) || (k == 16)));
    end

    // External rising edge, then a falling edge that must not tick
    @(negedge clk);
    bus.TCCR1B_in = 8'h07;
    repeat (4) @(negedge clk);
    bus.t1_pin = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      check("ext_rise_tick", 32'(bus.count_tick), 32'(k == 3));
    end
    @(negedge clk);
    bus.t1_pin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      check("ext_rise_nofall", 32'(bus.count_tick), 32'd0);
    end
    // Mirrored with falling-edge select
    @(negedge clk);
    bus.TCCR1B_in = 8'h06;
    bus.t1_pin = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      check("ext_fall_norise", 32'(bus.count_tick), 32'd0);
    end
    @(negedge clk);
    bus.t1_pin = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #2;
      check("ext_fall_tick", 32'(bus.count_tick), 32'(k == 3));
    end

    // Compare block after a CPU write coincident with a tick
    @(negedge clk);
    bus.TCCR1B_in = 8'h01;
    bus.OCR1AH_in = 8'h12;
    bus.OCR1AL_in = 8'h34;
    preset_req = 1'b1;
    preset_val = 16'h1000;
    @(negedge clk);
    preset_req = 1'b0;
    repeat (2) @(negedge clk);
    bus.cpu_tcnt_we = 1'b1;
    bus.cpu_tcnt_data = 16'h1234;
    #2;
    check("wr_tick",  32'(bus.count_tick), 32'd1);
    check("wr_next",  32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'h1234);
    check("wr_ocf",   32'(bus.ocf1a_set), 32'd0);
    @(negedge clk);
    bus.cpu_tcnt_we = 1'b0;
    #2;
    check("blk_tcnt", 32'(tcnt), 32'h1234);
    check("blk_ocf",  32'(bus.ocf1a_set), 32'd0);
    check("blk_next", 32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'h1235);
    @(negedge clk); #2;
    check("blk_after", 32'(tcnt), 32'h1235);
    // Unblocked normal-mode compare match
    @(negedge clk);
    preset_req = 1'b1;
    preset_val = 16'h1233;
    @(negedge clk);
    preset_req = 1'b0;
    #2;
    check("cmp_pre_ocf", 32'(bus.ocf1a_set), 32'd0);
    @(negedge clk); #2;
    check("cmp_tcnt", 32'(tcnt), 32'h1234);
    check("cmp_ocf",  32'(bus.ocf1a_set), 32'd1);

    // Interrupt request latency and drop
    @(negedge clk);
    bus.TIFR_in = 8'h14;
    bus.TIMSK_in = 8'h14;
    #2;
    check("irqc_lat0", 32'(bus.irq_compa), 32'd0);
    check("irqo_lat0", 32'(bus.irq_ovf), 32'd0);
    @(negedge clk); #2;
    check("irqc_lat1", 32'(bus.irq_compa), 32'd1);
    check("irqo_lat1", 32'(bus.irq_ovf), 32'd1);
    @(negedge clk);
    bus.TIFR_in = 8'h00;
    #2;
    check("irqc_hold", 32'(bus.irq_compa), 32'd1);
    @(negedge clk); #2;
    check("irqc_drop", 32'(bus.irq_compa), 32'd0);
    check("irqo_drop", 32'(bus.irq_ovf), 32'd0);
    @(negedge clk);
    bus.TIFR_in = 8'h10;
    repeat (2) @(negedge clk);
    #1;
    check("irqc_pre_rst", 32'(bus.irq_compa), 32'd1);

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_irqc", 32'(bus.irq_compa), 32'd0);
    check("arst_tick", 32'(bus.count_tick), 32'd0);
    check("arst_pre",  32'(dut.u_clk_sel.prescaler_q), 32'd0);
    check("arst_next", 32'({bus.TCNT1H_next, bus.TCNT1L_next}), 32'(tcnt));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/timer_16bit_count_unit.md
Name: timer_16bit_count_unit

Overview:
- Counting/compare engine for Timer/Counter1. Sits directly upstream of the 16-bit timer register file.
- Consumes the register file's current TCNT1, TCCR1B, OCR1A, TIMSK and TIFR values.
- Produces the next TCNT1 value, which the register file loads every cycle, plus one-cycle TIFR set strobes and registered interrupt requests to the interrupt controller.
- Owns the clock-select prescaler, external T1 pin synchronisation, CTC/normal-mode wrap, and compare-block-after-write.

Parameters:
PRESCALER_WIDTH, 10, width of the free-running prescaler counter (supports /1024).
SYNC_STAGES, 2, flip-flop stages synchronising t1_pin.
OCF_BIT, 4, bit index of OCF1A in TIFR/OCIE1A in TIMSK.
TOV_BIT, 2, bit index of TOV1 in TIFR/TOIE1 in TIMSK.

Ports:
sysClock  in  1  system clock; all state on rising edge.
system_reset  in  1  asynchronous, active-low reset.
TCCR1B_in  in  8  [2:0] CS1 clock select, [3] WGM12 (1 = CTC on OCR1A).
TCNT1H_in  in  8  current counter high byte (from register file).
TCNT1L_in  in  8  current counter low byte.
OCR1AH_in  in  8  compare value high byte.
OCR1AL_in  in  8  compare value low byte.
TIMSK_in  in  8  interrupt mask.
TIFR_in  in  8  current flag register.
cpu_tcnt_we  in  1  CPU writes TCNT1 this cycle.
cpu_tcnt_data  in  16  value written by CPU.
psr10  in  1  synchronous prescaler reset strobe.
t1_pin  in  1  external clock pin (asynchronous).
TCNT1H_next  out  8  next counter high byte.
TCNT1L_next  out  8  next counter low byte.
ocf1a_set  out  1  one-cycle strobe: set TIFR[OCF_BIT].
tov1_set  out  1  one-cycle strobe: set TIFR[TOV_BIT].
irq_compa  out  1  compare-A interrupt request.
irq_ovf  out  1  overflow interrupt request.
count_tick  out  1  registered timer-clock enable (observability).

Behaviour:
- Reset (system_reset=0, async):
  - prescaler, synchroniser, edge register, count_tick, compare-block flag, irq_compa and irq_ovf all clear to 0.
  - TCNT*_next follow TCNT*_in; strobes are 0.
- Prescaler:
  - Increments every sysClock cycle and wraps at 2^PRESCALER_WIDTH.
  - psr10=1 clears it to 0 on that edge; this takes priority over increment.
- Tick source by CS1 (tick is registered, so count_tick is asserted the cycle after the condition):
  - 000: stopped; no tick.
  - 001: tick every cycle.
  - 010: prescaler[2:0]==7.
  - 011: prescaler[5:0]==63.
  - 100: prescaler[7:0]==255.
  - 101: prescaler[9:0]==1023.
  - 110: falling edge of the synchronised t1_pin.
  - 111: rising edge of the synchronised t1_pin.
  - An edge on t1_pin yields count_tick exactly SYNC_STAGES+1 cycles later.
- Next-count, evaluated combinationally each cycle in priority order:
  1. cpu_tcnt_we=1: next = cpu_tcnt_data. No strobes. Set the compare-block flag.
  2. count_tick=1 and WGM12=1 and TCNT==OCR1A: next=0x0000, ocf1a_set=1 (unless blocked).
  3. count_tick=1 and TCNT==0xFFFF: next=0x0000, tov1_set=1. In normal mode, also set ocf1a_set=1 if OCR1A==0xFFFF and not blocked.
  4. count_tick=1: next = TCNT+1. In normal mode, ocf1a_set=1 if TCNT==OCR1A and not blocked.
  5. Otherwise: next = TCNT (hold).
- Arithmetic: the 16-bit increment is modulo 2^16. In CTC mode, TOV1 fires only if OCR1A==0xFFFF.
- Compare-block flag:
  - Set by a CPU write.
  - Cleared on the next count_tick; while set, ocf1a_set for that tick is suppressed.
  - If a write and a tick coincide, the write wins and the tick is discarded.
- Interrupt requests are registered:
  - irq_compa <= TIFR_in[OCF_BIT] & TIMSK_in[OCF_BIT].
  - irq_ovf <= TIFR_in[TOV_BIT] & TIMSK_in[TOV_BIT].
  - Latency is 1 cycle after the flag appears at TIFR_in. The request drops 1 cycle after the flag is cleared.
- Changing CS1 mid-run takes effect on the next cycle. The prescaler is not reset by a CS change.
- Reset mid-count: all state clears immediately; counting resumes from whatever TCNT_in holds after reset.

Decomposition:
- Shared package timer_pkg holds:
  - CS1 encodings (CS_STOP … CS_EXT_RISE).
  - WGM12 bit index; OCF_BIT and TOV_BIT defaults.
  - TCNT width constant (16).
- One natural sub-module: timer_clock_select. It contains the prescaler, the t1_pin synchroniser and edge detector, and the CS mux, and outputs the registered count_tick.
- The top level holds the next-count/compare logic, the compare-block flag, and the irq registers.

Test Plan:
- CS=001, WGM12=1, OCR1A=0x0003, TCNT starts 0x0000 -> TCNT sequence 0,1,2,3,0,1…; ocf1a_set pulses for one cycle while TCNT=3; tov1_set never asserts.
- CS=001, normal mode, TCNT preset 0xFFFE -> 0xFFFF then 0x0000; tov1_set=1 for exactly the wrap cycle.
- CS=010 from reset -> count_tick asserts once every 8 cycles. A psr10 pulse restarts the spacing, giving the next tick 8 cycles after the pulse.
- CS=111, one t1_pin rising edge -> exactly one count_tick, SYNC_STAGES+1=3 cycles after the edge. A falling edge gives no tick. With CS=110 the behaviour is mirrored.
- Counting with OCR1A=0x1234; CPU writes 0x1234 coincident with a tick -> next=0x1234, tick discarded. On the following tick no ocf1a_set is produced, and TCNT becomes 0x1235.
- TIFR_in[4]=1 with TIMSK_in[4]=1 -> irq_compa=1 one cycle later. Drive system_reset=0 mid-run -> irq_compa, count_tick and the prescaler go 0 immediately (asynchronously).
